// File: rtl/mod_bus_bridge.sv
// mod_bus_bridge
// Sequential bridge between the CPU data port and four memory-mapped slaves
// (cpuid, UART, switches/LEDs, timer). The 1 MB region tag daddr[31:20]
// selects a slave. The slave receives a region-relative offset, a one-hot
// enable and registered request fields. It completes the transfer by raising
// its s_ack bit. A slave that does not answer within TIMEOUT wait cycles, or
// an address that matches no region, raises a one-cycle bus_err pulse and
// records the failing address in err_addr.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   de, drw             CPU request enable and direction (1 = write)
//   daddr, din          CPU byte address and write data
//   dout                registered read data back to the CPU
//   stall               combinational hold request to the CPU
//   s_de                one-hot slave enable
//   s_rw, s_addr, s_din registered request fields presented to the slaves
//   s_dout0..s_dout3    slave read data
//   s_ack               per-slave completion strobe
//   bus_err             one-cycle error pulse (decode miss or timeout)
//   err_addr            address of the most recent error, held
module mod_bus_bridge #(
  parameter logic [11:0] BASE0   = 12'hf0a,
  parameter logic [11:0] BASE1   = 12'hf00,
  parameter logic [11:0] BASE2   = 12'hf01,
  parameter logic [11:0] BASE3   = 12'hf06,
  parameter int          TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        de,
  input  logic        drw,
  input  logic [31:0] daddr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        stall,
  output logic [3:0]  s_de,
  output logic        s_rw,
  output logic [31:0] s_addr,
  output logic [31:0] s_din,
  input  logic [31:0] s_dout0,
  input  logic [31:0] s_dout1,
  input  logic [31:0] s_dout2,
  input  logic [31:0] s_dout3,
  input  logic [3:0]  s_ack,
  output logic        bus_err,
  output logic [31:0] err_addr
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, ERR} state_t;

  // The counter value seen in the last wait cycle before the slave is
  // declared unresponsive.
  localparam logic [7:0] COUNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [1:0]  sel;
  logic [7:0]  count;
  logic [31:0] req_addr;

  logic        hit;
  logic [1:0]  hit_slot;
  logic        ack_sel;
  logic [31:0] rdata_sel;

  // Region decode. The order of the tests gives the lower slot priority when
  // two tags are configured identically.
  always_comb begin
    hit      = 1'b1;
    hit_slot = 2'd0;
    if (daddr[31:20] == BASE0) begin
      hit_slot = 2'd0;
    end else if (daddr[31:20] == BASE1) begin
      hit_slot = 2'd1;
    end else if (daddr[31:20] == BASE2) begin
      hit_slot = 2'd2;
    end else if (daddr[31:20] == BASE3) begin
      hit_slot = 2'd3;
    end else begin
      hit = 1'b0;
    end
  end

  // Only the ack and read data of the slave that owns the transfer matter.
  // Strobes on the other ack bits are ignored.
  always_comb begin
    ack_sel = s_ack[sel];
    case (sel)
      2'd0:    rdata_sel = s_dout0;
      2'd1:    rdata_sel = s_dout1;
      2'd2:    rdata_sel = s_dout2;
      default: rdata_sel = s_dout3;
    endcase
  end

  // Every state except WAIT can take a new request. The CPU is therefore held
  // whenever it presents one there, and it is held for the whole of WAIT.
  assign stall = (de && (state == IDLE || state == DONE || state == ERR)) ||
                 (state == WAIT);

  // Transfer sequencer. DONE and ERR each last a single cycle. Because they
  // accept requests exactly like IDLE, back-to-back transfers have no gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= 2'd0;
      count    <= 8'd0;
      req_addr <= 32'h0;
      dout     <= 32'h0;
      s_de     <= 4'b0000;
      s_rw     <= 1'b0;
      s_addr   <= 32'h0;
      s_din    <= 32'h0;
      bus_err  <= 1'b0;
      err_addr <= 32'h0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (de) begin
            if (hit) begin
              state    <= WAIT;
              sel      <= hit_slot;
              s_de     <= 4'b0001 << hit_slot;
              s_rw     <= drw;
              s_addr   <= {12'h000, daddr[19:0]};
              s_din    <= din;
              req_addr <= daddr;
              count    <= 8'd0;
            end else begin
              state    <= ERR;
              bus_err  <= 1'b1;
              err_addr <= daddr;
              dout     <= 32'h0;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          // An ack wins over a timeout that falls in the same cycle.
          if (ack_sel) begin
            if (!s_rw) begin
              dout <= rdata_sel;
            end
            s_de  <= 4'b0000;
            state <= DONE;
          end else if (count == COUNT_LAST) begin
            state    <= ERR;
            bus_err  <= 1'b1;
            err_addr <= req_addr;
            dout     <= 32'h0;
            s_de     <= 4'b0000;
          end else begin
            count <= count + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_bus_bridge.sv
// Self-checking bench for mod_bus_bridge. Behavioural slaves answer with
// programmable latency. A transaction-level model predicts the bridge outputs
// for every cycle, and one compare process checks them on each falling edge.
// A few literal expectations pin the model to hand-computed values.
module tb_mod_bus_bridge;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst;
  logic        de;
  logic        drw;
  logic [31:0] daddr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        stall;
  logic [3:0]  s_de;
  logic        s_rw;
  logic [31:0] s_addr;
  logic [31:0] s_din;
  logic [31:0] s_dout0, s_dout1, s_dout2, s_dout3;
  logic [3:0]  s_ack;
  logic        bus_err;
  logic [31:0] err_addr;

  mod_bus_bridge #(
    .BASE0(12'hf0a), .BASE1(12'hf00), .BASE2(12'hf01), .BASE3(12'hf06),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .de(de), .drw(drw), .daddr(daddr), .din(din),
    .dout(dout), .stall(stall), .s_de(s_de), .s_rw(s_rw), .s_addr(s_addr),
    .s_din(s_din), .s_dout0(s_dout0), .s_dout1(s_dout1), .s_dout2(s_dout2),
    .s_dout3(s_dout3), .s_ack(s_ack), .bus_err(bus_err), .err_addr(err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural slaves. lat[k] = n means the slave acks in the n-th cycle its
  // enable is high (1 means a combinational slave). 0 means it never acks.
  int         lat[4];
  int         cnt[4];
  logic [3:0] slave_ack;
  logic [3:0] stray_ack;

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) cnt[k] <= s_de[k] ? cnt[k] + 1 : 0;
  end

  always_comb begin
    slave_ack = 4'b0000;
    for (int k = 0; k < 4; k++)
      slave_ack[k] = s_de[k] && (lat[k] != 0) && (cnt[k] == lat[k] - 1);
  end

  assign s_ack   = slave_ack | stray_ack;
  assign s_dout0 = (s_addr == 32'h0) ? 32'hdeadbeef :
                   (s_addr == 32'h4) ? 32'h02faf080 : 32'h0;
  assign s_dout1 = 32'h000000a5;
  assign s_dout2 = 32'h5a5a0000 ^ s_addr;
  assign s_dout3 = 32'h71710000 | s_addr;

  // Model state: what every output must be in the current cycle.
  logic [11:0] bases[4] = '{12'hf0a, 12'hf00, 12'hf01, 12'hf06};
  logic [31:0] exp_dout, exp_err_addr, exp_s_addr, exp_s_din;
  logic [3:0]  exp_s_de;
  logic        exp_stall, exp_bus_err, exp_s_rw;
  bit          check_en, check_req;

  int n_checks = 0;
  int n_fail   = 0;
  int stall_run = 0, last_stall_run = 0;
  int sde_run = 0, last_sde_run = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual,
               expected, $time);
    end
  endtask

  // Per-cycle comparison against the model, plus run-length bookkeeping of
  // stall and slave enable that the literal checks use.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("dout", dout, exp_dout);
      checkOutput("stall", 32'(stall), 32'(exp_stall));
      checkOutput("s_de", 32'(s_de), 32'(exp_s_de));
      checkOutput("bus_err", 32'(bus_err), 32'(exp_bus_err));
      checkOutput("err_addr", err_addr, exp_err_addr);
      if (check_req) begin
        checkOutput("s_addr", s_addr, exp_s_addr);
        checkOutput("s_din", s_din, exp_s_din);
        checkOutput("s_rw", 32'(s_rw), 32'(exp_s_rw));
      end
    end
    if (stall) stall_run++;
    else begin
      if (stall_run != 0) last_stall_run = stall_run;
      stall_run = 0;
    end
    if (s_de != 4'b0000) sde_run++;
    else begin
      if (sde_run != 0) last_sde_run = sde_run;
      sde_run = 0;
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  function automatic int decodeSlot(input logic [31:0] a);
    for (int i = 0; i < 4; i++) if (a[31:20] == bases[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] slaveData(input int k, input logic [31:0] a);
    logic [31:0] off;
    off = {12'h000, a[19:0]};
    case (k)
      0: return (off == 32'h0) ? 32'hdeadbeef :
                (off == 32'h4) ? 32'h02faf080 : 32'h0;
      1: return 32'h000000a5;
      2: return 32'h5a5a0000 ^ off;
      default: return 32'h71710000 | off;
    endcase
  endfunction

  // Presents one request in the current cycle and follows it to its DONE or
  // ERR cycle. It returns inside that cycle with de already released, so the
  // caller can chain another request with no gap.
  task automatic applyStimulus(input logic [31:0] addr, input logic rw,
                               input logic [31:0] wdata);
    int k, waits;
    bit timed_out;
    k = decodeSlot(addr);
    de = 1'b1; drw = rw; daddr = addr; din = wdata;
    exp_stall = 1'b1;
    nextCycle();
    exp_bus_err = 1'b0;
    if (k < 0) begin
      de = 1'b0;
      exp_stall = 1'b0; exp_bus_err = 1'b1;
      exp_err_addr = addr; exp_dout = 32'h0; exp_s_de = 4'b0000;
      return;
    end
    if (lat[k] == 0 || lat[k] > TIMEOUT) begin
      waits = TIMEOUT; timed_out = 1'b1;
    end else begin
      waits = lat[k]; timed_out = 1'b0;
    end
    exp_s_de = 4'(1 << k);
    exp_s_addr = {12'h000, addr[19:0]}; exp_s_din = wdata; exp_s_rw = rw;
    check_req = 1'b1;
    repeat (waits) nextCycle();
    check_req = 1'b0;
    de = 1'b0;
    exp_stall = 1'b0; exp_s_de = 4'b0000;
    if (timed_out) begin
      exp_bus_err = 1'b1; exp_err_addr = addr; exp_dout = 32'h0;
    end else if (!rw) begin
      exp_dout = slaveData(k, addr);
    end
  endtask

  task automatic idleCycle();
    nextCycle();
    exp_bus_err = 1'b0;
    exp_stall = 1'b0;
  endtask

  initial begin
    rst = 1'b1; de = 1'b0; drw = 1'b0; daddr = 32'h0; din = 32'h0;
    stray_ack = 4'b0000;
    lat[0] = 1; lat[1] = 5; lat[2] = 1; lat[3] = 0;
    check_en = 1'b0; check_req = 1'b0;
    exp_dout = 32'h0; exp_err_addr = 32'h0; exp_s_addr = 32'h0;
    exp_s_din = 32'h0; exp_s_de = 4'b0000; exp_stall = 1'b0;
    exp_bus_err = 1'b0; exp_s_rw = 1'b0;

    nextCycle();
    check_en = 1'b1;
    nextCycle();
    rst = 1'b0;
    checkOutput("lit_reset_dout", dout, 32'h0);
    checkOutput("lit_reset_s_addr", s_addr, 32'h0);
    idleCycle();

    // Zero-wait cpuid read: stall spans the accept and WAIT cycles.
    applyStimulus(32'hf0a00000, 1'b0, 32'h0);
    settle();
    checkOutput("lit_cpuid_id", dout, 32'hdeadbeef);
    checkOutput("lit_read_stall_cycles", 32'(last_stall_run), 32'd2);
    idleCycle();

    // Back-to-back reads: the second request is presented in the DONE cycle.
    applyStimulus(32'hf0a00000, 1'b0, 32'h0);
    applyStimulus(32'hf0a00004, 1'b0, 32'h0);
    settle();
    checkOutput("lit_cpuid_freq", dout, 32'h02faf080);
    idleCycle();

    // Decode miss.
    applyStimulus(32'h20000000, 1'b0, 32'h0);
    settle();
    checkOutput("lit_miss_bus_err", 32'(bus_err), 32'd1);
    checkOutput("lit_miss_err_addr", err_addr, 32'h20000000);
    checkOutput("lit_miss_dout", dout, 32'h0);
    idleCycle();

    // UART with five wait cycles. Strobes arrive on the other ack bits.
    stray_ack = 4'b1101;
    applyStimulus(32'hf0000000, 1'b0, 32'h0);
    settle();
    checkOutput("lit_uart_stall_cycles", 32'(last_stall_run), 32'd6);
    checkOutput("lit_uart_dout", dout, 32'h000000a5);
    stray_ack = 4'b0000;
    idleCycle();

    // Timer never answers a write and times out.
    lat[3] = 0;
    applyStimulus(32'hf0600010, 1'b1, 32'h12345678);
    settle();
    checkOutput("lit_to_s_din", s_din, 32'h12345678);
    checkOutput("lit_to_s_addr", s_addr, 32'h00000010);
    checkOutput("lit_to_err_addr", err_addr, 32'hf0600010);
    checkOutput("lit_to_wait_cycles", 32'(last_sde_run), 32'd16);
    idleCycle();

    // Switch/LED write (dout holds), then read back. Timer read with wait states.
    applyStimulus(32'hf0100008, 1'b1, 32'hcafef00d);
    applyStimulus(32'hf0100008, 1'b0, 32'h0);
    lat[3] = 3;
    applyStimulus(32'hf0600020, 1'b0, 32'h0);
    settle();
    checkOutput("lit_timer_dout", dout, 32'h71710020);
    idleCycle();

    // An ack in the final allowed cycle wins. One cycle later is a timeout.
    // A new hit follows directly out of the ERR cycle.
    lat[1] = TIMEOUT;
    applyStimulus(32'hf0000004, 1'b0, 32'h0);
    idleCycle();
    lat[1] = TIMEOUT + 1;
    applyStimulus(32'hf0000008, 1'b0, 32'h0);
    applyStimulus(32'hf0a00004, 1'b0, 32'h0);
    idleCycle();

    // Reset arrives in the third WAIT cycle of a UART read.
    lat[1] = 5;
    de = 1'b1; drw = 1'b0; daddr = 32'hf0000000; din = 32'h0;
    exp_stall = 1'b1;
    nextCycle();
    exp_s_de = 4'b0010; exp_s_addr = 32'h0; exp_s_din = 32'h0;
    exp_s_rw = 1'b0; check_req = 1'b1;
    nextCycle();
    nextCycle();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0; de = 1'b0; check_req = 1'b0;
    exp_dout = 32'h0; exp_s_de = 4'b0000; exp_err_addr = 32'h0;
    exp_bus_err = 1'b0; exp_stall = 1'b0;
    settle();
    checkOutput("lit_rst_dout", dout, 32'h0);
    checkOutput("lit_rst_s_de", 32'(s_de), 32'h0);
    checkOutput("lit_rst_bus_err", 32'(bus_err), 32'h0);
    idleCycle();
    applyStimulus(32'hf0a00000, 1'b0, 32'h0);
    idleCycle();
    idleCycle();

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
